usb_tx_sequencer: RTL and testbench
===================================

Name: usb_tx_sequencer

Overview:
- Packet-level controller for the USB transmit path.
- Sequences one full packet on a start pulse:
  - SYNC byte, then PID byte.
  - LEN data bytes, pulled from the TX FIFO.
  - Optional CRC16 bytes.
  - Triggers and waits on the EOP generator.
- Sits between the host-side TX FIFO/packet registers and the byte shifter (NRZI/bit-stuff stage) and EOP generator; sole owner of the EOP generator's selection/clear inputs.

Parameters:
- LEN_W, 7: width of the data-length field; packet carries 0..2^LEN_W-1 data bytes.
- SYNC_BYTE, 8'h80: byte sent as SYNC (LSB-first 00000001).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_start  in  1  one-cycle request; sampled only in IDLE
- tx_pid  in  4  PID nibble, latched on accepted tx_start
- tx_len  in  LEN_W  data byte count, latched on accepted tx_start
- fifo_data  in  8  show-ahead FIFO head byte
- fifo_empty  in  1  FIFO empty flag
- fifo_rd  out  1  pop FIFO head (one-cycle pulse per data byte transferred)
- byte_out  out  8  byte to shifter
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  shifter accepts byte this cycle
- eop_sel  out  1  EOP generator selection
- eop_clear  out  1  EOP generator counter clear
- eop_done  in  1  EOP generator completion pulse
- tx_busy  out  1  high whenever state != IDLE
- tx_done  out  1  one-cycle pulse, packet complete
- tx_error  out  1  one-cycle pulse, FIFO underrun abort

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0; byte_out 8'h00.
  - Latched PID/len, byte counter and CRC register are cleared (CRC to 16'hFFFF).
  - Reset mid-packet aborts immediately; no EOP is issued.
- Handshake: a byte transfers on a rising edge where byte_valid & byte_ready. byte_out is held stable while byte_valid=1 and not accepted. byte_valid never drops without a transfer, except on underrun (see DATA).
- State sequence:
  - IDLE:
    - On tx_start: latch tx_pid and tx_len, set counter=0, CRC=16'hFFFF, go to SYNC.
    - tx_start is ignored in every other state.
  - SYNC: byte_out=SYNC_BYTE, byte_valid=1. On transfer go to PID.
  - PID:
    - byte_out={~pid,pid}, byte_valid=1.
    - On transfer: go to DATA if len!=0; otherwise CRC_LO (CRC16 build) or EOP_CLR (no CRC16).
  - DATA:
    - byte_out=fifo_data; byte_valid=!fifo_empty.
    - On transfer: fifo_rd=1 in the same cycle, CRC updated with the byte, counter+1.
    - When counter reaches len-1 and a transfer occurs, go to CRC_LO or EOP_CLR.
    - If fifo_empty is sampled in DATA: tx_error=1 for one cycle, go to EOP_CLR (packet aborted, no CRC sent).
  - CRC_LO: byte_out=~crc[7:0]. On transfer go to CRC_HI.
  - CRC_HI: byte_out=~crc[15:8]. On transfer go to EOP_CLR.
  - EOP_CLR: eop_clear=1, eop_sel=0 for exactly one cycle, then go to EOP_RUN.
  - EOP_RUN:
    - eop_sel=1 held; byte_valid=0.
    - On eop_done=1, go to DONE. eop_sel deasserts the cycle after eop_done.
    - No timeout.
  - DONE: tx_done=1 for one cycle, then go to IDLE. A tx_start in the DONE cycle is dropped.
- CRC16 definition:
  - Reflected polynomial 16'hA001, LSB-first per byte, init 16'hFFFF.
  - Transmitted value is the complement, low byte first.
  - Covers data bytes only; PID and SYNC are excluded.
- Minimum packet with ready always high, len=0, CRC on:
  - SYNC, PID, CRC_LO, CRC_HI: 4 byte cycles.
  - EOP_CLR: 1 cycle.
  - EOP_RUN: until eop_done.
  - DONE: 1 cycle.

Optional Feature:
- USB_TX_CRC16_EN:
  - Defined: CRC_LO/CRC_HI states exist, and the CRC16 sub-module is instantiated.
  - Undefined: PID/DATA exit directly to EOP_CLR, no CRC logic is built, and the byte count on the wire is 2+len.

Decomposition:
- Package usb_tx_pkg holds:
  - State enum (IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_CLR, EOP_RUN, DONE).
  - CRC16_INIT=16'hFFFF and CRC16_POLY_REFL=16'hA001.
  - Default SYNC constant.
- Sub-module usb_crc16_byte: combinational next-CRC from (crc_in[15:0], data[7:0]); the register lives in the sequencer.

Test Plan:
- Len=0, pid=4'h3, ready=1, eop_done 20 cycles after eop_sel rises:
  - bytes 80, C3, 00, 00;
  - eop_clear pulse one cycle before eop_sel;
  - tx_done one cycle after eop_done; tx_busy low after.
- Len=9, FIFO holds ASCII "123456789", pid=4'hB:
  - bytes 80, 4B, 31..39, C8, B4;
  - exactly 9 fifo_rd pulses.
- byte_ready toggled randomly, len=4: byte_out stable while valid & !ready; byte order and count unchanged.
- FIFO goes empty after 2 of len=5 bytes: tx_error one pulse, no CRC bytes, EOP_CLR/EOP_RUN still executed, tx_done follows eop_done.
- n_rst asserted mid-DATA: all outputs 0 asynchronously; next tx_start yields a clean packet starting with 80.
- With USB_TX_CRC16_EN undefined, len=2 data AA 55: bytes 80, PID, AA, 55, then EOP.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB transmit sequencer.
//   tx_state_e      - packet sequencer states
//   CRC16_INIT      - CRC16 register seed
//   CRC16_POLY_REFL - reflected CRC16 polynomial (x^16+x^15+x^2+1)
//   SYNC_DEFAULT    - SYNC byte, LSB-first 00000001 on the wire
package usb_tx_pkg;

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_CLR, EOP_RUN, DONE
  } tx_state_e;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [7:0]  SYNC_DEFAULT    = 8'h80;

endpackage

// File: rtl/usb_crc16_byte.sv
// usb_crc16_byte: combinational one-byte CRC16 step, LSB-first, reflected poly.
// Only built when USB_TX_CRC16_EN is defined; the state register lives in the
// sequencer.
//   crc_in  [15:0] current CRC register
//   data    [7:0]  byte being transmitted
//   crc_out [15:0] CRC after absorbing data
`ifdef USB_TX_CRC16_EN
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    crc_out = c;
  end

endmodule
`endif

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: packet-level USB TX controller.
// Sends SYNC, PID, LEN data bytes from a show-ahead FIFO, optional CRC16,
// then drives the EOP generator and reports completion.
// Build option: USB_TX_CRC16_EN adds the CRC_LO/CRC_HI bytes and CRC logic.
// Ports:
//   clk, n_rst                    clock, async active-low reset
//   tx_start/tx_pid/tx_len        packet request (sampled in IDLE only)
//   fifo_data/fifo_empty/fifo_rd  TX FIFO head, empty flag, pop strobe
//   byte_out/byte_valid/byte_ready byte handshake to the shifter
//   eop_sel/eop_clear/eop_done    EOP generator control
//   tx_busy/tx_done/tx_error      status (done/error are one-cycle pulses)
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int          LEN_W     = 7,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             eop_sel,
  output logic             eop_clear,
  input  logic             eop_done,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_error
);

  tx_state_e        state;
  logic [3:0]       pid_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             last_data;

`ifdef USB_TX_CRC16_EN
  localparam tx_state_e AFTER_DATA = CRC_LO;
  logic [15:0] crc_q;
  logic [15:0] crc_nxt;

  usb_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data    (fifo_data),
    .crc_out (crc_nxt)
  );
`else
  localparam tx_state_e AFTER_DATA = EOP_CLR;
`endif

  assign last_data = (cnt_q == len_q - LEN_W'(1));

  // Outputs decode from the state register only, except in DATA where the
  // FIFO head is forwarded straight through (show-ahead) and the pop strobe
  // must coincide with the shifter accepting the byte.
  always_comb begin
    byte_out   = 8'h00;
    byte_valid = 1'b0;
    fifo_rd    = 1'b0;
    eop_sel    = 1'b0;
    eop_clear  = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    tx_busy    = (state != IDLE);
    case (state)
      SYNC: begin
        byte_out   = SYNC_BYTE;
        byte_valid = 1'b1;
      end
      PID: begin
        byte_out   = {~pid_q, pid_q};
        byte_valid = 1'b1;
      end
      DATA: begin
        byte_out   = fifo_data;
        byte_valid = !fifo_empty;
        fifo_rd    = !fifo_empty && byte_ready;
        tx_error   = fifo_empty;
      end
`ifdef USB_TX_CRC16_EN
      CRC_LO: begin
        byte_out   = ~crc_q[7:0];
        byte_valid = 1'b1;
      end
      CRC_HI: begin
        byte_out   = ~crc_q[15:8];
        byte_valid = 1'b1;
      end
`endif
      EOP_CLR: eop_clear = 1'b1;
      EOP_RUN: eop_sel   = 1'b1;
      DONE:    tx_done   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      pid_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
`ifdef USB_TX_CRC16_EN
      crc_q <= CRC16_INIT;
`endif
    end else begin
      case (state)
        IDLE: if (tx_start) begin
          pid_q <= tx_pid;
          len_q <= tx_len;
          cnt_q <= '0;
`ifdef USB_TX_CRC16_EN
          crc_q <= CRC16_INIT;
`endif
          state <= SYNC;
        end
        SYNC: if (byte_ready) state <= PID;
        PID:  if (byte_ready) state <= (len_q != '0) ? DATA : AFTER_DATA;
        DATA: begin
          // Underrun: abort the packet but still close it with an EOP.
          if (fifo_empty) state <= EOP_CLR;
          else if (byte_ready) begin
            cnt_q <= cnt_q + LEN_W'(1);
`ifdef USB_TX_CRC16_EN
            crc_q <= crc_nxt;
`endif
            if (last_data) state <= AFTER_DATA;
          end
        end
`ifdef USB_TX_CRC16_EN
        CRC_LO: if (byte_ready) state <= CRC_HI;
        CRC_HI: if (byte_ready) state <= EOP_CLR;
`endif
        EOP_CLR: state <= EOP_RUN;
        EOP_RUN: if (eop_done) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb_usb_tx_sequencer: randomized self-checking bench for usb_tx_sequencer.
// Expected byte streams come from a packet model (SYNC, PID, data, bit-serial
// CRC16) built from the packet format, not from the sequencer's states.
module tb_usb_tx_sequencer;

  localparam int LEN_W = 7;
`ifdef USB_TX_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic             clk = 1'b0;
  logic             n_rst;
  logic             tx_start;
  logic [3:0]       tx_pid;
  logic [LEN_W-1:0] tx_len;
  logic [7:0]       fifo_data;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             eop_sel;
  logic             eop_clear;
  logic             eop_done;
  logic             tx_busy;
  logic             tx_done;
  logic             tx_error;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .tx_len(tx_len), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .eop_sel(eop_sel), .eop_clear(eop_clear),
    .eop_done(eop_done), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_error(tx_error)
  );

  int  n_checks = 0;
  int  n_pass   = 0;
  bq_t fifo_q;
  bq_t obs;
  int  n_rd, n_err, n_done, n_clr, stable_viol;
  int  cyc_clr, cyc_sel, cyc_eopdone, cyc_done;
  bit  busy_after, timed_out;

  // CRC16/USB computed one bit at a time, LSB first.
  function automatic logic [15:0] ref_crc(input bq_t d);
    logic [15:0] c = 16'hFFFF;
    logic        fb;
    foreach (d[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  // Wire image of one packet given the bytes actually available in the FIFO.
  function automatic bq_t model_pkt(input logic [3:0] pid, input int len, input bq_t avail);
    bq_t         e;
    bq_t         d;
    logic [15:0] c;
    e.push_back(8'h80);
    e.push_back({~pid, pid});
    for (int i = 0; i < len && i < avail.size(); i++) begin
      e.push_back(avail[i]);
      d.push_back(avail[i]);
    end
    if (CRC_ON && avail.size() >= len) begin
      c = ref_crc(d);
      e.push_back(~c[7:0]);
      e.push_back(~c[15:8]);
    end
    return e;
  endfunction

  task automatic fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // Issues one tx_start and records everything the DUT does until the cycle
  // after tx_done. Inputs change #1 after posedge, outputs sampled at negedge.
  task automatic run_packet(input logic [3:0] pid, input int len, input bit rnd,
                            input int eop_delay, input bit noise);
    int         cyc;
    bit         hold, prev_sel, pop;
    logic [7:0] prev_b;
    obs = {};
    n_rd = 0; n_err = 0; n_done = 0; n_clr = 0; stable_viol = 0;
    cyc_clr = -1; cyc_sel = -1; cyc_eopdone = -1; cyc_done = -1;
    busy_after = 1'b1; timed_out = 1'b1;
    hold = 1'b0; prev_sel = 1'b0; prev_b = 8'h00;
    fifo_drive();
    tx_pid = pid; tx_len = LEN_W'(len); tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (byte_valid && byte_ready) obs.push_back(byte_out);
      if (hold && (!byte_valid || byte_out !== prev_b)) stable_viol++;
      hold   = byte_valid && !byte_ready;
      prev_b = byte_out;
      pop    = fifo_rd;
      if (fifo_rd) n_rd++;
      if (tx_error) n_err++;
      if (eop_clear) begin n_clr++; cyc_clr = cyc; end
      if (eop_sel && !prev_sel) cyc_sel = cyc;
      prev_sel = eop_sel;
      if (eop_done) cyc_eopdone = cyc;
      if (tx_done) begin n_done++; cyc_done = cyc; end
      if (cyc_done >= 0 && cyc == cyc_done + 1) begin
        busy_after = tx_busy; timed_out = 1'b0; tx_start = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (pop) void'(fifo_q.pop_front());
      fifo_drive();
      byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      eop_done   = (cyc_sel >= 0 && cyc + 1 == cyc_sel + eop_delay);
      tx_start   = noise && ($urandom_range(0, 3) == 0);
      tx_pid     = 4'($urandom);
      tx_len     = LEN_W'($urandom);
    end
    tx_start = 1'b0; eop_done = 1'b0; byte_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; tx_start = 1'b0; tx_pid = '0; tx_len = '0;
    byte_ready = 1'b1; eop_done = 1'b0; fifo_q = {}; fifo_drive();
    #12;
    n_checks++;
    if ({byte_out, byte_valid, fifo_rd, eop_sel, eop_clear, tx_busy, tx_done, tx_error} !== 15'h0)
      $display("FAIL reset_outputs: got %0h expected 0",
               {byte_out, byte_valid, fifo_rd, eop_sel, eop_clear, tx_busy, tx_done, tx_error});
    else n_pass++;
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx_busy, byte_valid, eop_sel} !== 3'b000)
      $display("FAIL idle_after_reset: got %b expected 000", {tx_busy, byte_valid, eop_sel});
    else n_pass++;
  endtask

  task automatic test_len0();
    bq_t e;
    e = model_pkt(4'h3, 0, fifo_q);
    run_packet(4'h3, 0, 1'b0, 20, 1'b0);
    n_checks++;
    if (obs.size() != e.size()) $display("FAIL len0_count: got %0d expected %0d", obs.size(), e.size());
    else n_pass++;
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== e[i]) $display("FAIL len0_byte%0d: got %h expected %h", i, obs[i], e[i]);
      else n_pass++;
    end
    n_checks++;
    if (timed_out || n_clr != 1 || cyc_sel != cyc_clr + 1)
      $display("FAIL len0_eop_clear: clr=%0d@%0d sel@%0d expected 1 pulse one cycle before sel",
               n_clr, cyc_clr, cyc_sel);
    else n_pass++;
    n_checks++;
    if (cyc_eopdone != cyc_sel + 20) $display("FAIL len0_eop_wait: got %0d expected %0d", cyc_eopdone, cyc_sel + 20);
    else n_pass++;
    n_checks++;
    if (n_done != 1 || cyc_done != cyc_eopdone + 1)
      $display("FAIL len0_done: got %0d pulses @%0d expected 1 @%0d", n_done, cyc_done, cyc_eopdone + 1);
    else n_pass++;
    n_checks++;
    if (busy_after !== 1'b0 || n_rd != 0) $display("FAIL len0_idle: busy=%b rd=%0d expected 0 0", busy_after, n_rd);
    else n_pass++;
  endtask

  task automatic test_len9();
    bq_t d, e;
    logic [15:0] tail;
    for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
    fifo_q = d;
    e = model_pkt(4'hB, 9, d);
    run_packet(4'hB, 9, 1'b0, 5, 1'b0);
    n_checks++;
    if (timed_out || obs.size() != e.size()) $display("FAIL len9_count: got %0d expected %0d", obs.size(), e.size());
    else n_pass++;
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== e[i]) $display("FAIL len9_byte%0d: got %h expected %h", i, obs[i], e[i]);
      else n_pass++;
    end
`ifdef USB_TX_CRC16_EN
    tail = (obs.size() == 13) ? {obs[11], obs[12]} : 16'hxxxx;
    n_checks++;
    if (tail !== 16'hC8B4) $display("FAIL len9_crc: got %h expected C8B4", tail);
    else n_pass++;
`else
    tail = 16'h0;
`endif
    n_checks++;
    if (n_rd != 9 || n_err != 0) $display("FAIL len9_fifo_rd: got %0d rd %0d err expected 9 0", n_rd, n_err);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    bq_t d, e;
    int  len;
    logic [3:0] pid;
    for (int it = 0; it < 4; it++) begin
      len = (it == 0) ? 4 : (it == 1) ? 127 : $urandom_range(1, 12);
      pid = 4'($urandom);
      d = {};
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      fifo_q = d;
      e = model_pkt(pid, len, d);
      run_packet(pid, len, 1'b1, $urandom_range(1, 10), 1'b1);
      n_checks++;
      if (timed_out || obs.size() != e.size())
        $display("FAIL rnd%0d_count: got %0d expected %0d", it, obs.size(), e.size());
      else n_pass++;
      for (int i = 0; i < e.size() && i < obs.size(); i++) begin
        n_checks++;
        if (obs[i] !== e[i]) $display("FAIL rnd%0d_byte%0d: got %h expected %h", it, i, obs[i], e[i]);
        else n_pass++;
      end
      n_checks++;
      if (stable_viol != 0) $display("FAIL rnd%0d_stable: got %0d violations expected 0", it, stable_viol);
      else n_pass++;
      n_checks++;
      if (n_rd != len || n_err != 0 || n_done != 1 || busy_after !== 1'b0)
        $display("FAIL rnd%0d_status: rd=%0d err=%0d done=%0d busy=%b expected %0d 0 1 0",
                 it, n_rd, n_err, n_done, busy_after, len);
      else n_pass++;
    end
  endtask

  task automatic test_underrun();
    bq_t d, e;
    d = '{8'h11, 8'h22};
    fifo_q = d;
    e = model_pkt(4'h6, 5, d);
    run_packet(4'h6, 5, 1'b0, 7, 1'b0);
    n_checks++;
    if (timed_out || obs.size() != e.size()) $display("FAIL urun_count: got %0d expected %0d", obs.size(), e.size());
    else n_pass++;
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== e[i]) $display("FAIL urun_byte%0d: got %h expected %h", i, obs[i], e[i]);
      else n_pass++;
    end
    n_checks++;
    if (n_err != 1 || n_rd != 2) $display("FAIL urun_error: got %0d err %0d rd expected 1 2", n_err, n_rd);
    else n_pass++;
    n_checks++;
    if (n_clr != 1 || cyc_sel != cyc_clr + 1 || n_done != 1 || cyc_done != cyc_eopdone + 1)
      $display("FAIL urun_eop: clr=%0d sel@%0d clr@%0d done=%0d@%0d eopdone@%0d expected clean EOP then done",
               n_clr, cyc_sel, cyc_clr, n_done, cyc_done, cyc_eopdone);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bq_t e;
    fifo_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    fifo_drive();
    byte_ready = 1'b1;
    tx_pid = 4'h9; tx_len = LEN_W'(5); tx_start = 1'b1;
    @(posedge clk); #1; tx_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!(tx_busy && byte_valid && fifo_rd)) $display("FAIL rstmid_in_data: got busy=%b valid=%b rd=%b expected 1 1 1",
                                                      tx_busy, byte_valid, fifo_rd);
    else n_pass++;
    n_rst = 1'b0; #1;
    n_checks++;
    if ({byte_out, byte_valid, fifo_rd, eop_sel, eop_clear, tx_busy, tx_done, tx_error} !== 15'h0)
      $display("FAIL rstmid_async: got %0h expected 0",
               {byte_out, byte_valid, fifo_rd, eop_sel, eop_clear, tx_busy, tx_done, tx_error});
    else n_pass++;
    @(negedge clk); n_rst = 1'b1;
    fifo_q = {};
    @(negedge clk);
    e = model_pkt(4'h5, 0, fifo_q);
    run_packet(4'h5, 0, 1'b0, 3, 1'b0);
    n_checks++;
    if (timed_out || obs.size() != e.size() || obs[0] !== 8'h80)
      $display("FAIL rstmid_restart: got %0d bytes first %h expected %0d bytes first 80",
               obs.size(), (obs.size() > 0) ? obs[0] : 8'hxx, e.size());
    else n_pass++;
  endtask

  task automatic test_len2();
    bq_t d, e;
    d = '{8'hAA, 8'h55};
    fifo_q = d;
    e = model_pkt(4'h1, 2, d);
    run_packet(4'h1, 2, 1'b0, 2, 1'b0);
    n_checks++;
    if (timed_out || obs.size() != e.size()) $display("FAIL len2_count: got %0d expected %0d", obs.size(), e.size());
    else n_pass++;
    for (int i = 0; i < e.size() && i < obs.size(); i++) begin
      n_checks++;
      if (obs[i] !== e[i]) $display("FAIL len2_byte%0d: got %h expected %h", i, obs[i], e[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_len9();
    test_random_ready();
    test_underrun();
    test_reset_mid();
    test_len2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
